// File: rtl/ser_bit_feeder.sv
// ser_bit_feeder: parallel-to-serial feeder for the serial run-detect FSM.
//
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock on ser_out. ser_out is held at 0 whenever no data bit is being
// driven (idle, gap, after flush/reset), so the downstream detector falls back
// to its start state between words. A one-entry hold buffer lets words stream
// back-to-back with no bubble when GAP_CYCLES == 0.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   GAP_CYCLES forced-0 cycles after each word's last bit (0..15)
//   MSB_FIRST  1: send bit WIDTH-1 first, 0: send bit 0 first
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_data/in_valid word offered upstream
//   in_ready         combinational: !hold_full && !flush
//   flush            synchronous abort of the current and the held word
//   ser_out          registered serial bit
//   ser_active       registered, ser_out carries a data bit
//   word_done        registered pulse coincident with each word's last bit
//   busy             state != IDLE or hold buffer full
module ser_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             ser_out,
    output logic             ser_active,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
    // Gap counter counts down the remaining gap cycles; 0 marks the final one.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic [3:0]       gcnt;

    logic             accept;
    logic             last_bit;
    logic             start_ok;
    logic             load_hold;
    logic             load_in;
    logic             load;
    logic             to_hold;
    logic [WIDTH-1:0] load_word;
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             next_bit;
    logic [WIDTH-1:0] next_rest;

    assign in_ready = !hold_full && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE) || hold_full;

    always_comb begin
        last_bit  = (state == SHIFT) && (cnt == LAST_IDX);
        // A new word may start at the next edge from IDLE, at the end of the
        // last bit when there is no gap, or at the final gap cycle.
        start_ok  = (state == IDLE)
                  || (last_bit && (GAP_CYCLES == 0))
                  || ((state == GAP) && (gcnt == 4'd0));
        // The held word always has priority; it is older than any new accept.
        load_hold = start_ok && hold_full;
        load_in   = start_ok && !hold_full && accept;
        load      = load_hold || load_in;
        to_hold   = accept && !load_in;
        load_word = hold_full ? hold : in_data;

        // shreg keeps the not-yet-sent bits aligned so the next bit is always
        // at the same end; the bit on ser_out has already been shifted away.
        if (MSB_FIRST) begin
            load_bit  = load_word[WIDTH-1];
            load_rest = load_word << 1;
            next_bit  = shreg[WIDTH-1];
            next_rest = shreg << 1;
        end else begin
            load_bit  = load_word[0];
            load_rest = load_word >> 1;
            next_bit  = shreg[0];
            next_rest = shreg >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            cnt        <= '0;
            gcnt       <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            word_done  <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            shreg      <= '0;
            hold_full  <= 1'b0;
            cnt        <= '0;
            gcnt       <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            word_done <= 1'b0;

            // Refill wins over drain so a same-cycle drain+accept keeps both.
            if (to_hold) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                state      <= SHIFT;
                shreg      <= load_rest;
                ser_out    <= load_bit;
                ser_active <= 1'b1;
                cnt        <= '0;
                gcnt       <= GAP_LAST;
            end else begin
                case (state)
                    SHIFT: begin
                        if (last_bit) begin
                            state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gcnt       <= GAP_LAST;
                            ser_out    <= 1'b0;
                            ser_active <= 1'b0;
                        end else begin
                            ser_out    <= next_bit;
                            shreg      <= next_rest;
                            ser_active <= 1'b1;
                            cnt        <= cnt + 1'b1;
                            word_done  <= (cnt == PRE_LAST);
                        end
                    end
                    GAP: begin
                        if (gcnt == 4'd0) state <= IDLE;
                        else              gcnt  <= gcnt - 4'd1;
                        ser_out    <= 1'b0;
                        ser_active <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        ser_out    <= 1'b0;
                        ser_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_bit_feeder.sv
// Bench for ser_bit_feeder: three instances (no gap MSB-first, 2-cycle gap
// MSB-first, no gap LSB-first) share one input stream. A timeline model
// schedules every accepted word at max(accept+1, end of previous word + gap)
// and records the expected serial bits per cycle.
module tb_ser_bit_feeder;

    localparam int W  = 8;
    localparam int NC = 2048;
    localparam int GP [3] = '{0, 2, 0};
    localparam bit MF [3] = '{1'b1, 1'b1, 1'b0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   rdy, so, sa, wd, bz;

    always #5 clk = ~clk;

    ser_bit_feeder #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .flush(flush), .ser_out(so[0]), .ser_active(sa[0]),
        .word_done(wd[0]), .busy(bz[0]));
    ser_bit_feeder #(.WIDTH(W), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .flush(flush), .ser_out(so[1]), .ser_active(sa[1]),
        .word_done(wd[1]), .busy(bz[1]));
    ser_bit_feeder #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[2]), .flush(flush), .ser_out(so[2]), .ser_active(sa[2]),
        .word_done(wd[2]), .busy(bz[2]));

    // Expected per-cycle outputs, plus the two most recent words' schedule.
    bit eb [3][NC];
    bit ea [3][NC];
    bit ed [3][NC];
    int ws [3][2];   // first-bit cycle
    int we [3][2];   // first cycle after the word's trailing gap
    int wa [3][2];   // accept cycle
    int free_at [3];
    int cyc = 0;
    int total = 0;
    int passes = 0;
    int fails = 0;

    function automatic bit m_hold(int p, int c);
        bit h = 1'b0;
        for (int k = 0; k < 2; k++)
            if (wa[p][k] >= 0 && wa[p][k] < c && ws[p][k] > c) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_busy(int p, int c);
        bit b = m_hold(p, c);
        for (int k = 0; k < 2; k++)
            if (ws[p][k] >= 0 && ws[p][k] <= c && c < we[p][k]) b = 1'b1;
        return b;
    endfunction

    task automatic m_clear(int p, int from);
        for (int i = from; i < NC; i++) begin
            eb[p][i] = 1'b0; ea[p][i] = 1'b0; ed[p][i] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            ws[p][k] = -1; we[p][k] = -1; wa[p][k] = -1;
        end
        free_at[p] = from;
    endtask

    task automatic m_accept(int p, logic [W-1:0] d, int c);
        int s = (c + 1 > free_at[p]) ? c + 1 : free_at[p];
        for (int k = 0; k < W; k++) begin
            if (s + k < NC) begin
                eb[p][s+k] = MF[p] ? d[W-1-k] : d[k];
                ea[p][s+k] = 1'b1;
                ed[p][s+k] = (k == W - 1);
            end
        end
        ws[p][0] = ws[p][1]; we[p][0] = we[p][1]; wa[p][0] = wa[p][1];
        ws[p][1] = s; we[p][1] = s + W + GP[p]; wa[p][1] = c;
        free_at[p] = s + W + GP[p];
    endtask

    task automatic chk(string tag, int p, logic obs, logic exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s u%0d cyc=%0d got=%b want=%b", tag, p, cyc, obs, exp);
        end
    endtask

    task automatic chk_outs();
        for (int p = 0; p < 3; p++) begin
            chk("ser_out",    p, so[p], (cyc < NC) ? eb[p][cyc] : 1'b0);
            chk("ser_active", p, sa[p], (cyc < NC) ? ea[p][cyc] : 1'b0);
            chk("word_done",  p, wd[p], (cyc < NC) ? ed[p][cyc] : 1'b0);
            chk("busy",       p, bz[p], m_busy(p, cyc));
        end
    endtask

    // One clock cycle: check outputs, apply inputs, check in_ready, advance model.
    task automatic step(bit v, logic [W-1:0] d, bit f);
        bit r;
        @(negedge clk);
        chk_outs();
        in_valid = v; in_data = d; flush = f;
        #1;
        for (int p = 0; p < 3; p++) begin
            r = !m_hold(p, cyc) && !f;
            chk("in_ready", p, rdy[p], r);
            if (rst_n) begin
                if (f)          m_clear(p, cyc + 1);
                else if (v && r) m_accept(p, d, cyc);
            end
        end
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        chk_outs();
        in_valid = 1'b0; flush = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            chk("rst_ser_out",    p, so[p], 1'b0);
            chk("rst_ser_active", p, sa[p], 1'b0);
            chk("rst_word_done",  p, wd[p], 1'b0);
            chk("rst_busy",       p, bz[p], 1'b0);
            m_clear(p, cyc);
        end
        cyc++;
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 3; p++) m_clear(p, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // single word, 1110_0000 on MSB-first units
        step(1'b1, 8'hE0, 1'b0);
        idle(14);
        // back-to-back pair through the hold buffer
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        idle(24);
        // gap separation
        step(1'b1, 8'hC0, 1'b0);
        step(1'b1, 8'hC0, 1'b0);
        idle(24);
        // LSB-first check word
        step(1'b1, 8'h07, 1'b0);
        idle(12);
        // flush on the 4th bit of FF with AA held; concurrent accept ignored
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        idle(2);
        step(1'b1, 8'h55, 1'b1);
        idle(12);
        // reset mid-word, then a clean 8'h80
        step(1'b1, 8'h3C, 1'b0);
        idle(3);
        pulse_reset();
        step(1'b1, 8'h80, 1'b0);
        idle(12);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 700; i++)
            step(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 49) == 0));
        idle(24);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/ser_bit_feeder.md
Name: ser_bit_feeder

Overview:
- Parallel-to-serial feeder directly upstream of the serial run-detect FSM.
- Accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock on ser_out, which connects straight to the detector's serial input.
- Holds ser_out at 0 whenever idle or in a gap, so the downstream run detector returns to its start state between words.
- Has a one-entry holding buffer so words can stream back-to-back with no bubble.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- GAP_CYCLES, 0, number of forced-0 cycles inserted after each word's last bit; legal range 0..15.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  feeder can accept a word; accept = in_valid && in_ready.
- flush  input  1  synchronous abort of the current word and the buffered word.
- ser_out  output  1  serial bit to the detector; registered.
- ser_active  output  1  ser_out carries a data bit this cycle; registered.
- word_done  output  1  one-cycle pulse, coincident with the last bit of each word.
- busy  output  1  state != IDLE or holding buffer full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, shifter cleared, bit count cleared, hold empty.
  - ser_out=0, ser_active=0, word_done=0.
  - in_ready=1 as soon as rst_n is released.
- in_ready is combinational: !hold_full && !flush. It never depends on in_valid.
- State machine:
  - IDLE
    - Accept with hold empty: word loads the shifter directly; next state SHIFT.
    - The first bit appears on ser_out in the cycle after the accept. Latency is 1.
  - SHIFT
    - Each cycle: drive the next bit, set ser_active=1, increment the count.
    - On the cycle that presents bit index WIDTH-1 (the last bit):
      - word_done=1.
      - If GAP_CYCLES>0: next state GAP.
      - Else if hold is full: the hold word loads into the shifter, hold empties, stay in SHIFT.
      - Else if an accept occurs this cycle: the accepted word loads into the shifter directly, stay in SHIFT.
      - Else: next state IDLE.
  - GAP
    - ser_out=0 and ser_active=0 for exactly GAP_CYCLES cycles.
    - Then load from hold, or from a same-cycle accept, into SHIFT; otherwise go to IDLE.
- Accept while in SHIFT or GAP, where the word is not consumed directly: the word goes into hold, and in_ready drops the next cycle.
- Simultaneous hold drain and accept in the same cycle: the hold word goes to the shifter and the accepted word refills hold. No word is lost and no word is duplicated.
- Bit ordering:
  - MSB_FIRST=1 sends in_data[WIDTH-1] down to in_data[0].
  - MSB_FIRST=0 sends in_data[0] up to in_data[WIDTH-1].
- ser_out is 0 whenever ser_active is 0.
- flush (synchronous):
  - Takes effect at the next edge: state=IDLE, hold empty, ser_out=0, ser_active=0, word_done=0.
  - The bit count returns to 0.
  - in_ready is 0 during the flush cycle, so no word can be accepted while flush is high.
  - A partially sent word is not resumed.
- Reset mid-word: the same end result as flush, applied asynchronously. Outputs go low immediately.
- in_data is sampled only on accept. Changes to in_data at other times have no effect.
- The bit counter is ceil(log2(WIDTH)) bits wide. The gap counter is 4 bits wide. Neither counter wraps silently; each reloads at every word start.

Test Plan:
- WIDTH=8, MSB_FIRST=1, single word 8'hE0 accepted at cycle t -> ser_out = 1,1,1,0,0,0,0,0 in cycles t+1..t+8; ser_active=1 for those 8 cycles; word_done only at t+8; ser_out=0 and busy=0 from t+9.
- Back-to-back with GAP_CYCLES=0: in_valid held high with words 8'hFF then 8'h01 -> 16 contiguous active bits, 1x8 then 0000_0001; in_ready is low while hold is full; word_done fires at bits 8 and 16.
- GAP_CYCLES=2: words 8'hC0 and 8'hC0 queued -> exactly 2 cycles of ser_out=0 with ser_active=0 between the words; downstream detector output stays 0.
- MSB_FIRST=0: word 8'h07 -> ser_out = 1,1,1,0,0,0,0,0; word_done on the 8th bit.
- flush asserted at the 4th bit of 8'hFF with 8'hAA held -> next cycle ser_out=0, busy=0, in_ready=1; 8'hAA is never sent; an accept attempted in the flush cycle is ignored.
- rst_n pulsed low mid-word -> ser_out, ser_active and word_done drop asynchronously; after release, a new word 8'h80 is sent cleanly: 1 then seven 0s.
